uart_wb_bridge: RTL
===================

# uart_wb_bridge

Wishbone B4 pipelined single-word bus master driven by a byte stream, used as a host debug and load port. It accepts framed read/write commands from the UART receive byte interface and issues one 32-bit Wishbone transaction per command. It returns a status byte, plus read data, on a transmit byte handshake. It is the initiator counterpart to the existing Wishbone slaves and sits in front of the data-side slave decoder as a second bus master.

## Interface
- TIMEOUT_CYCLES, 1024: bus cycles allowed from `stb_o` assertion to `ack_i`/`err_i` before the command is aborted; width of the counter is clog2(TIMEOUT_CYCLES+1).
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- rx_byte_i  in  8  received byte; qualified by `rx_valid_i`.
- rx_valid_i  in  1  one-cycle strobe, byte available.
- tx_byte_o  out  8  byte to transmit.
- tx_valid_o  out  1  `tx_byte_o` valid; held until accepted.
- tx_ready_i  in  1  transmitter accepts when `tx_valid_o` and `tx_ready_i` are both high.
- busy_o  out  1  high in every state except IDLE.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master control.
- wb_adr_o  out  32  word address; bits [1:0] always 0.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  always 4'hF.
- wb_stall_i, wb_ack_i, wb_err_i  in  1 each  slave response.
- wb_dat_i  in  32  read data; sampled on `ack_i`.

## Operation
- Frame: command byte, then 4 address bytes (MSB first), then, for writes only, 4 data bytes (MSB first).
- Commands: 0x57 = write, 0x52 = read. Any other byte received in IDLE is discarded and the block stays in IDLE.
- Response: one status byte, 0x06 = OK or 0x15 = error/timeout. A successful read is followed by 4 data bytes, MSB first. A failed read sends the status byte only.
- States: IDLE → ADDR (4 bytes) → DATA (write only, 4 bytes) → BUS_REQ → BUS_WAIT → RESP_STATUS → RESP_DATA (successful read only) → IDLE.
- A 2-bit byte counter is shared by ADDR, DATA and RESP_DATA and wraps 3→0 at each state exit.
- Bytes arriving while in BUS_REQ, BUS_WAIT, RESP_STATUS or RESP_DATA are dropped.
- BUS_REQ: `cyc_o`, `stb_o` = 1. `stb_o` is held while `stall_i` = 1. On the first cycle with `stall_i` = 0, `stb_o` drops next cycle and the state moves to BUS_WAIT.
- BUS_WAIT: `cyc_o` = 1 until `ack_i` or `err_i`.
- `ack_i`/`err_i` are honoured in BUS_REQ too, provided `stall_i` = 0 in that cycle.
- If `ack_i` and `err_i` arrive together, `err_i` wins.
- Timeout: the counter clears on entry to BUS_REQ and increments every bus cycle. Reaching TIMEOUT_CYCLES drops `cyc_o`/`stb_o` and sends status 0x15. A late `ack_i` after that is ignored.
- `wb_we_o` = 1 for writes for the whole cycle, 0 for reads.

## Timing
- All outputs are registered.
- Reset values: `wb_cyc_o`, `wb_stb_o`, `wb_we_o` = 0; `wb_adr_o`, `wb_dat_o` = 0; `wb_sel_o` = 4'hF; `tx_valid_o` = 0; `tx_byte_o` = 0; `busy_o` = 0; state = IDLE.
- The cycle after the last frame byte's `rx_valid_i`, `cyc_o`/`stb_o` are high.
- The cycle after ack/err, `cyc_o` = 0 and `tx_valid_o` = 1 with the status byte.
- Each response byte is held stable while `tx_valid_o` = 1 and `tx_ready_i` = 0. On acceptance the next byte is presented the following cycle. After the last byte, `tx_valid_o` drops and the state is IDLE.
- Minimum read latency with a zero-wait slave (ack one cycle after stb): last address byte → status valid = 3 cycles.
- Reset mid-transaction aborts immediately: `cyc_o` drops asynchronously and no response byte is sent.

## Structure
- Package `uart_wb_bridge_pkg` holds the CMD_WRITE/CMD_READ and STAT_OK/STAT_ERR constants and the state enum.
- Natural sub-module: `wb_single_master`, covering BUS_REQ/BUS_WAIT, the timeout counter, the `cyc`/`stb` handshake and the captured read data, with a start/done/error interface to the frame FSM.

## Test plan
- Write: bytes 57 00 00 00 10 DE AD BE EF, slave acks after 1 cycle → one cycle with `adr_o`=0x10, `dat_o`=0xDEADBEEF, `we_o`=1, `sel_o`=F; TX 0x06.
- Read: 52 00 00 80 14 with a slave returning 0x00000001 → `we_o`=0; TX 06 00 00 00 01.
- Stall: slave holds `stall_i` for 3 cycles → `stb_o` stays high for 4 cycles, exactly one transaction, TX 0x06.
- Error and timeout: `err_i` → TX 0x15 only. No response, TIMEOUT_CYCLES=16 → `cyc_o` drops after 16 cycles, TX 0x15; an ack at cycle 20 is ignored.
- Framing: junk 0x41 in IDLE → ignored, `busy_o`=0. RX bytes during the response → dropped. `tx_ready_i` low for 5 cycles → `tx_byte_o` stable.
- Reset asserted in BUS_WAIT → `cyc_o`=0 at once, `tx_valid_o`=0; a subsequent read completes normally.

Source files
------------

// File: rtl/uart_wb_bridge_pkg.sv
// Shared definitions for the UART-to-Wishbone debug bridge.
// Holds the command and status byte codes, the frame FSM state
// encoding and the state encoding of the single-word bus master.
package uart_wb_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] STAT_OK   = 8'h06;
    localparam logic [7:0] STAT_ERR  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS_REQ,
        ST_BUS_WAIT,
        ST_RESP_STATUS,
        ST_RESP_DATA
    } bridge_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_REQ,
        M_WAIT
    } master_state_t;

    // Byte idx of a word, counted from the most significant end.
    function automatic logic [7:0] msb_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_wb_bridge_master.sv
// Single-word Wishbone B4 pipelined master with a bus timeout.
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   start_i, we_i               launch one transaction (we_i: write)
//   done_o, error_o             combinational completion pulse, valid the
//                               cycle the response (or timeout) is taken
//   rdata_o                     read data captured on ack
//   wb_cyc_o/stb_o/we_o         registered bus controls
//   wb_stall_i/ack_i/err_i      slave response
//   wb_dat_i                    slave read data
module wb_single_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        we_i,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] rdata_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i
);
    import uart_wb_bridge_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter is 0 in the first bus cycle, so the last allowed cycle
    // sees TIMEOUT_CYCLES-1 and cyc drops after exactly TIMEOUT_CYCLES.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    master_state_t state, state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          resp_ok;
    logic          tmo_hit;

    always_comb begin
        state_nxt = state;
        done_o    = 1'b0;
        resp_ok   = 1'b0;
        tmo_hit   = (state != M_IDLE) && (tmo_cnt == TMO_LAST);
        case (state)
            M_IDLE: begin
                if (start_i)
                    state_nxt = M_REQ;
            end
            M_REQ: begin
                // A response only counts once the request has been accepted.
                resp_ok = !wb_stall_i && (wb_ack_i || wb_err_i);
                if (resp_ok || tmo_hit) begin
                    done_o    = 1'b1;
                    state_nxt = M_IDLE;
                end else if (!wb_stall_i) begin
                    state_nxt = M_WAIT;
                end
            end
            M_WAIT: begin
                resp_ok = wb_ack_i || wb_err_i;
                if (resp_ok || tmo_hit) begin
                    done_o    = 1'b1;
                    state_nxt = M_IDLE;
                end
            end
            default: state_nxt = M_IDLE;
        endcase
        // err beats ack; a timeout without any response is an error.
        error_o = done_o && (!resp_ok || wb_err_i);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= M_IDLE;
            tmo_cnt  <= '0;
            rdata_o  <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wb_cyc_o <= (state_nxt != M_IDLE);
            wb_stb_o <= (state_nxt == M_REQ);
            if (state == M_IDLE) begin
                tmo_cnt <= '0;
                wb_we_o <= start_i ? we_i : 1'b0;
            end else begin
                tmo_cnt <= tmo_cnt + CW'(1);
                if (state_nxt == M_IDLE)
                    wb_we_o <= 1'b0;
            end
            if (done_o && resp_ok && !wb_err_i)
                rdata_o <= wb_dat_i;
        end
    end

endmodule

// File: rtl/uart_wb_bridge.sv
// Byte-stream driven Wishbone master used as a host debug/load port.
// Frames: cmd (0x57 write / 0x52 read), 4 address bytes, 4 data bytes for
// writes, all MSB first. Replies with a status byte (0x06 ok / 0x15 error or
// timeout) followed by 4 read-data bytes on a successful read.
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   rx_byte_i, rx_valid_i       received byte and its one-cycle strobe
//   tx_byte_o, tx_valid_o       response byte, held until tx_ready_i
//   tx_ready_i                  transmitter accepts the byte
//   busy_o                      high whenever the frame FSM is not idle
//   wb_*                        Wishbone B4 pipelined master port
module uart_wb_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_byte_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i
);
    import uart_wb_bridge_pkg::*;

    bridge_state_t state, state_nxt;
    logic [1:0]    byte_cnt;
    logic          is_read;
    logic          read_ok;
    logic [23:0]   adr_sh;
    logic [23:0]   dat_sh;
    logic          start;
    logic          tx_accept;
    logic          m_done;
    logic          m_error;
    logic [31:0]   m_rdata;

    assign wb_sel_o = 4'hF;

    wb_single_master #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_master (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .start_i    (start),
        .we_i       (!is_read),
        .done_o     (m_done),
        .error_o    (m_error),
        .rdata_o    (m_rdata),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_stall_i (wb_stall_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_dat_i   (wb_dat_i)
    );

    // start is raised in the same cycle as the last frame byte so that the
    // master registers cyc/stb on that edge.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        tx_accept = tx_valid_o && tx_ready_i;
        case (state)
            ST_IDLE: begin
                if (rx_valid_i && (rx_byte_i == CMD_WRITE || rx_byte_i == CMD_READ))
                    state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (rx_valid_i && byte_cnt == 2'd3) begin
                    if (is_read) begin
                        state_nxt = ST_BUS_REQ;
                        start     = 1'b1;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid_i && byte_cnt == 2'd3) begin
                    state_nxt = ST_BUS_REQ;
                    start     = 1'b1;
                end
            end
            ST_BUS_REQ: begin
                if (m_done)
                    state_nxt = ST_RESP_STATUS;
                else if (!wb_stall_i)
                    state_nxt = ST_BUS_WAIT;
            end
            ST_BUS_WAIT: begin
                if (m_done)
                    state_nxt = ST_RESP_STATUS;
            end
            ST_RESP_STATUS: begin
                if (tx_accept)
                    state_nxt = read_ok ? ST_RESP_DATA : ST_IDLE;
            end
            ST_RESP_DATA: begin
                if (tx_accept && byte_cnt == 2'd3)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            byte_cnt   <= 2'd0;
            is_read    <= 1'b0;
            read_ok    <= 1'b0;
            adr_sh     <= '0;
            dat_sh     <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            tx_byte_o  <= '0;
            tx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_ADDR) begin
                        is_read  <= (rx_byte_i == CMD_READ);
                        byte_cnt <= 2'd0;
                    end
                end
                ST_ADDR: begin
                    if (rx_valid_i) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            wb_adr_o <= {adr_sh, rx_byte_i[7:2], 2'b00};
                        else
                            adr_sh <= {adr_sh[15:0], rx_byte_i};
                    end
                end
                ST_DATA: begin
                    if (rx_valid_i) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            wb_dat_o <= {dat_sh, rx_byte_i};
                        else
                            dat_sh <= {dat_sh[15:0], rx_byte_i};
                    end
                end
                ST_BUS_REQ, ST_BUS_WAIT: begin
                    if (m_done) begin
                        tx_valid_o <= 1'b1;
                        tx_byte_o  <= m_error ? STAT_ERR : STAT_OK;
                        read_ok    <= is_read && !m_error;
                    end
                end
                ST_RESP_STATUS: begin
                    if (tx_accept) begin
                        if (read_ok) begin
                            tx_byte_o <= msb_byte(m_rdata, 2'd0);
                            byte_cnt  <= 2'd0;
                        end else begin
                            tx_valid_o <= 1'b0;
                        end
                    end
                end
                ST_RESP_DATA: begin
                    if (tx_accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            tx_valid_o <= 1'b0;
                        else
                            tx_byte_o <= msb_byte(m_rdata, byte_cnt + 2'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
